// File: rtl/frame_buf_sched.sv
// Triple-buffer scheduler: rotates write/ready/display frame buffers on frame events.
// Optional statistics counters are built when FBS_STATS_EN is defined.
module frame_buf_sched #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [31:0] FRAME_BYTES = 32'h0075_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr_frame_start,
    input  logic        wr_frame_done,
    input  logic        rd_frame_start,
    output logic [31:0] wr_base,
    output logic [31:0] rd_base,
    output logic [1:0]  wr_idx,
    output logic [1:0]  rd_idx,
    output logic        fresh,
    output logic [15:0] drop_cnt,
    output logic [15:0] repeat_cnt,
    output logic [15:0] abort_cnt
);

    typedef enum logic {IDLE, BUSY} wr_state_t;

    wr_state_t  state, state_nx;
    logic [1:0] w_q, r_q, d_q;
    logic [1:0] w_nx, r_nx, d_nx;
    logic       fresh_q, fresh_nx;
    logic       commit;

    function automatic logic [31:0] addr_of(input logic [1:0] idx);
        return BASE_ADDR + 32'(idx) * FRAME_BYTES;
    endfunction

    // Next-state: writer FSM, commit swap (W<->R), then read swap (D<->R)
    always_comb begin
        state_nx = state;
        w_nx     = w_q;
        r_nx     = r_q;
        d_nx     = d_q;
        fresh_nx = fresh_q;
        commit   = 1'b0;
        if (enable) begin
            unique case (state)
                IDLE: if (wr_frame_start) state_nx = BUSY;
                BUSY: begin
                    if (wr_frame_done) begin
                        commit = 1'b1;
                        if (!wr_frame_start) state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
            if (commit) begin
                w_nx     = r_q;
                r_nx     = w_q;
                fresh_nx = 1'b1;
            end
            if (rd_frame_start && fresh_nx) begin
                d_nx     = r_nx;
                r_nx     = d_q;
                fresh_nx = 1'b0;
            end
        end
    end

    // State and registered outputs, derived from next-state indices
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            w_q     <= 2'd0;
            r_q     <= 2'd1;
            d_q     <= 2'd2;
            fresh_q <= 1'b0;
            wr_base <= BASE_ADDR;
            rd_base <= BASE_ADDR + 32'd2 * FRAME_BYTES;
        end else begin
            state   <= state_nx;
            w_q     <= w_nx;
            r_q     <= r_nx;
            d_q     <= d_nx;
            fresh_q <= fresh_nx;
            wr_base <= addr_of(w_nx);
            rd_base <= addr_of(d_nx);
        end
    end

    assign wr_idx = w_q;
    assign rd_idx = d_q;
    assign fresh  = fresh_q;

`ifdef FBS_STATS_EN
    logic [15:0] drop_q, repeat_q, abort_q;

    // Saturating event counters for drops, repeats and aborted writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q   <= 16'h0;
            repeat_q <= 16'h0;
            abort_q  <= 16'h0;
        end else if (enable) begin
            if (commit && fresh_q && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
            if (rd_frame_start && !commit && !fresh_q && repeat_q != 16'hFFFF)
                repeat_q <= repeat_q + 16'd1;
            if (state == BUSY && wr_frame_start && !wr_frame_done
                && abort_q != 16'hFFFF)
                abort_q <= abort_q + 16'd1;
        end
    end

    assign drop_cnt   = drop_q;
    assign repeat_cnt = repeat_q;
    assign abort_cnt  = abort_q;
`else
    assign drop_cnt   = 16'h0;
    assign repeat_cnt = 16'h0;
    assign abort_cnt  = 16'h0;
`endif

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed testbench for frame_buf_sched.
// Counter expectations follow the FBS_STATS_EN build option.
module tb_frame_buf_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        wr_frame_start = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic [31:0] wr_base, rd_base;
    logic [1:0]  wr_idx, rd_idx;
    logic        fresh;
    logic [15:0] drop_cnt, repeat_cnt, abort_cnt;

    int tests = 0;
    int fails = 0;

`ifdef FBS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    frame_buf_sched dut (
        .clk(clk), .rst(rst), .enable(enable),
        .wr_frame_start(wr_frame_start),
        .wr_frame_done(wr_frame_done),
        .rd_frame_start(rd_frame_start),
        .wr_base(wr_base), .rd_base(rd_base),
        .wr_idx(wr_idx), .rd_idx(rd_idx), .fresh(fresh),
        .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt),
        .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cexp(input int v);
        return STATS ? 16'(v) : 16'h0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // drive one cycle of pulses, return 1 time unit after the sampling edge
    task automatic pulse(input logic s, input logic d, input logic r);
        @(negedge clk);
        wr_frame_start = s;
        wr_frame_done  = d;
        rd_frame_start = r;
        @(posedge clk);
        #1;
        wr_frame_start = 1'b0;
        wr_frame_done  = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        chk("rst wr_base", wr_base, 32'h8000_0000);
        chk("rst rd_base", rd_base, 32'h80EA_6000);
        chk("rst wr_idx", 32'(wr_idx), 32'd0);
        chk("rst rd_idx", 32'(rd_idx), 32'd2);
        chk("rst fresh", 32'(fresh), 32'd0);
        chk("rst drop", 32'(drop_cnt), 32'd0);
        chk("rst repeat", 32'(repeat_cnt), 32'd0);
        chk("rst abort", 32'(abort_cnt), 32'd0);
    endtask

    task automatic test_commit_read();
        do_reset();
        pulse(1, 0, 0);
        chk("cr busy wr_idx", 32'(wr_idx), 32'd0);
        pulse(0, 1, 0);
        chk("cr wr_idx", 32'(wr_idx), 32'd1);
        chk("cr wr_base", wr_base, 32'h8075_3000);
        chk("cr fresh", 32'(fresh), 32'd1);
        chk("cr rd_idx hold", 32'(rd_idx), 32'd2);
        pulse(0, 0, 1);
        chk("cr rd_idx", 32'(rd_idx), 32'd0);
        chk("cr rd_base", rd_base, 32'h8000_0000);
        chk("cr fresh clr", 32'(fresh), 32'd0);
        chk("cr repeat", 32'(repeat_cnt), 32'(cexp(0)));
    endtask

    task automatic test_drop();
        do_reset();
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("drop wr_idx1", 32'(wr_idx), 32'd1);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("drop wr_idx0", 32'(wr_idx), 32'd0);
        chk("drop rd_idx", 32'(rd_idx), 32'd2);
        chk("drop cnt", 32'(drop_cnt), 32'(cexp(1)));
        pulse(0, 0, 1);
        chk("drop rd_idx1", 32'(rd_idx), 32'd1);
        chk("drop rd_base", rd_base, 32'h8075_3000);
    endtask

    task automatic test_repeat();
        do_reset();
        for (int i = 0; i < 3; i++) pulse(0, 0, 1);
        chk("rep cnt", 32'(repeat_cnt), 32'(cexp(3)));
        chk("rep rd_base", rd_base, 32'h80EA_6000);
        chk("rep rd_idx", 32'(rd_idx), 32'd2);
    endtask

    task automatic test_same_cycle();
        do_reset();
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        chk("sc rd_idx", 32'(rd_idx), 32'd0);
        chk("sc wr_idx", 32'(wr_idx), 32'd1);
        chk("sc fresh", 32'(fresh), 32'd0);
        chk("sc drop", 32'(drop_cnt), 32'(cexp(0)));
        chk("sc repeat", 32'(repeat_cnt), 32'(cexp(0)));
        // W=1 R=2 D=0 now; next write commit swaps W and R
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("sc wr_idx2", 32'(wr_idx), 32'd2);
        chk("sc wr_base2", wr_base, 32'h80EA_6000);
    endtask

    task automatic test_abort();
        do_reset();
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        chk("ab wr_idx busy", 32'(wr_idx), 32'd0);
        pulse(0, 1, 0);
        chk("ab cnt", 32'(abort_cnt), 32'(cexp(1)));
        chk("ab wr_idx", 32'(wr_idx), 32'd1);
        chk("ab drop", 32'(drop_cnt), 32'(cexp(0)));
        pulse(0, 1, 0);
        chk("ab idle done", 32'(wr_idx), 32'd1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse(1, 0, 0);
        pulse(1, 1, 0);
        chk("b2b wr_idx", 32'(wr_idx), 32'd1);
        chk("b2b abort", 32'(abort_cnt), 32'(cexp(0)));
        pulse(0, 1, 0);
        chk("b2b wr_idx2", 32'(wr_idx), 32'd0);
        chk("b2b drop", 32'(drop_cnt), 32'(cexp(1)));
        chk("b2b fresh", 32'(fresh), 32'd1);
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b0;
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        chk("en wr_idx", 32'(wr_idx), 32'd0);
        chk("en rd_idx", 32'(rd_idx), 32'd2);
        chk("en fresh", 32'(fresh), 32'd0);
        chk("en repeat", 32'(repeat_cnt), 32'(cexp(0)));
        enable = 1'b1;
        pulse(0, 1, 0);
        chk("en lost start", 32'(wr_idx), 32'd0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(1, 0, 0);
        chk("mid pre wr_idx", 32'(wr_idx), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid wr_idx", 32'(wr_idx), 32'd0);
        chk("mid wr_base", wr_base, 32'h8000_0000);
        chk("mid rd_base", rd_base, 32'h80EA_6000);
        chk("mid fresh", 32'(fresh), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulse(0, 1, 0);
        chk("mid busy clr", 32'(wr_idx), 32'd0);
    endtask

    initial begin
        test_reset();
        test_commit_read();
        test_drop();
        test_repeat();
        test_same_cycle();
        test_abort();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
